apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
// Two-requester APB master controller. Arbitrates round-robin between two command ports,
// sequences each accepted command through APB IDLE->SETUP->ACCESS, and returns one
// response per command. Guards against hung slaves with a wait-state timeout.
// Drives the Psel/Penable/Pwrite/Paddr/Pwdata bus and samples Prdata/Pready/Pslverr.
// PARAMETERS
// ADDR_WIDTH  8   APB address width
// DATA_WIDTH  32  APB read/write data width
// TIMEOUT     16  max ACCESS cycles before forced error completion; 0 = timeout disabled
// PORTS
// Pclk       in   1             clock, all logic on rising edge
// Presetn    in   1             asynchronous active-low reset
// req_valid  in   2             per-requester command valid (bit i = requester i)
// req_write  in   2             1 = write, 0 = read
// req_addr   in   2*ADDR_WIDTH  requester i in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
// req_wdata  in   2*DATA_WIDTH  requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
// req_ready  out  2             command accepted this cycle (combinational, one-hot or 0)
// rsp_valid  out  2             one-cycle response pulse to requester i
// rsp_rdata  out  DATA_WIDTH    read data; 0 for writes and timeouts
// rsp_err    out  1             Pslverr seen, or timeout
// Psel       out  1             APB select
// Penable    out  1             APB enable
// Pwrite     out  1             APB direction
// Paddr      out  ADDR_WIDTH    APB address
// Pwdata     out  DATA_WIDTH    APB write data
// Prdata     in   DATA_WIDTH    APB read data
// Pready     in   1             APB slave ready
// Pslverr    in   1             APB slave error, valid only when Pready=1
// BEHAVIOUR
// - Reset (Presetn=0, async): state IDLE; all outputs 0; RR pointer = requester 0;
//   timeout counter 0. An in-flight transfer is dropped without a response.
// - Handshake: valid/ready. Requester holds valid, write, addr and wdata stable until ready.
//   A command is taken in the cycle req_ready[i]=1.
// - Arbitration: grant goes to the pointer requester if it is valid, else to the other one.
//   After each grant the pointer moves to the non-granted requester.
// - FSM (registered outputs):
//   IDLE:   Psel=0, Penable=0. Any valid -> req_ready[g]=1, latch cmd + g -> SETUP.
//   SETUP:  Psel=1, Penable=0, Paddr/Pwrite/Pwdata = latched cmd. Always -> ACCESS.
//   ACCESS: Psel=1, Penable=1, bus held stable. Done when Pready=1 or timeout fires.
//           On done, next cycle: rsp_valid[g]=1, rsp_err=Pslverr,
//           rsp_rdata=Prdata when read else 0.
//           If any req_valid in the done cycle: accept it (req_ready pulse), -> SETUP (back-to-back).
//           Otherwise -> IDLE.
// - Timeout: counter clears on entering ACCESS and increments on each ACCESS cycle with Pready=0.
//   With TIMEOUT>0, Pready=0 and count==TIMEOUT-1: forced done, rsp_err=1, rsp_rdata=0.
// - Latency: accept in cycle N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid N+3 (zero wait states).
//   Each wait state adds one cycle.
// - rsp_valid, rsp_rdata and rsp_err are valid for exactly one cycle, then return to 0.
// - Paddr, Pwrite and Pwdata hold their last values in IDLE. req_ready is never asserted in SETUP.
//   It is asserted in ACCESS only in the done cycle.
// - Both requesters valid simultaneously: they alternate strictly (0,1,0,1...).
// TESTING
// 1. Single write, req0 addr=0x10 wdata=0xDEADBEEF, Pready=1 -> SETUP N+1, ACCESS N+2,
//    rsp_valid=01 at N+3, rsp_err=0, rsp_rdata=0.
// 2. Read req1 addr=0x24, Pready low 3 cycles then high with Prdata=0x1234 ->
//    ACCESS lasts 4 cycles, rsp_valid=10, rsp_rdata=0x1234.
// 3. Both valid continuously, 4 cmds each -> grants 0,1,0,1...; back-to-back SETUP with no IDLE between.
// 4. Pready=1 with Pslverr=1 on write -> rsp_err=1. Pslverr=1 while Pready=0 -> ignored.
// 5. TIMEOUT=16, Pready held 0 -> done after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0,
//    Psel=0 next cycle.
// 6. Presetn low during ACCESS -> all outputs 0 immediately, no rsp_valid.
//    After release, the next grant goes to requester 0.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration between command ports, an
// IDLE/SETUP/ACCESS bus sequencer, one response per command, and a wait-state timeout.
module apb_master_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    Pclk,
    input  logic                    Presetn,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    Psel,
    output logic                    Penable,
    output logic                    Pwrite,
    output logic [ADDR_WIDTH-1:0]   Paddr,
    output logic [DATA_WIDTH-1:0]   Pwdata,
    input  logic [DATA_WIDTH-1:0]   Prdata,
    input  logic                    Pready,
    input  logic                    Pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    ptr_r;
    logic                    gnt_r;
    logic [CW-1:0]           cnt_r;
    logic                    psel_r;
    logic                    penable_r;
    logic                    pwrite_r;
    logic [ADDR_WIDTH-1:0]   paddr_r;
    logic [DATA_WIDTH-1:0]   pwdata_r;
    logic [1:0]              rsp_valid_r;
    logic                    rsp_err_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;

    logic                    gnt_s;
    logic                    timeout_s;
    logic                    done_s;
    logic                    accept_s;

    // Arbitration, completion detection and next-state selection
    always_comb begin
        gnt_s       = 1'b0;
        timeout_s   = 1'b0;
        done_s      = 1'b0;
        accept_s    = 1'b0;
        req_ready   = 2'b00;
        state_nxt_s = state_r;

        if (req_valid[ptr_r]) begin
            gnt_s = ptr_r;
        end else begin
            gnt_s = ~ptr_r;
        end

        if ((TIMEOUT > 0) && (state_r == ST_ACCESS) && !Pready && (cnt_r == TO_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end

        done_s = (state_r == ST_ACCESS) && (Pready || timeout_s);
        // Gated by Presetn so req_ready is also forced low while reset is asserted.
        accept_s = Presetn && (|req_valid) && ((state_r == ST_IDLE) || done_s);

        if (accept_s) begin
            req_ready = gnt_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (accept_s) begin
                    state_nxt_s = ST_SETUP;
                end else if (done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered bus control strobes
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state_r   <= ST_IDLE;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            psel_r    <= (state_nxt_s != ST_IDLE);
            penable_r <= (state_nxt_s == ST_ACCESS);
        end
    end

    // Command capture on acceptance; bus fields hold their value otherwise
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            ptr_r    <= 1'b0;
            gnt_r    <= 1'b0;
            pwrite_r <= 1'b0;
            paddr_r  <= {ADDR_WIDTH{1'b0}};
            pwdata_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            ptr_r    <= ~gnt_s;
            gnt_r    <= gnt_s;
            pwrite_r <= req_write[gnt_s];
            paddr_r  <= gnt_s ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
            pwdata_r <= gnt_s ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        end else begin
            ptr_r    <= ptr_r;
            gnt_r    <= gnt_r;
            pwrite_r <= pwrite_r;
            paddr_r  <= paddr_r;
            pwdata_r <= pwdata_r;
        end
    end

    // Wait-state counter: cleared in SETUP, counts not-ready ACCESS cycles
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            cnt_r <= {CW{1'b0}};
        end else if (state_r == ST_SETUP) begin
            cnt_r <= {CW{1'b0}};
        end else if ((state_r == ST_ACCESS) && !Pready) begin
            cnt_r <= cnt_r + 1'b1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // One-cycle response pulse following the completing ACCESS cycle
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            rsp_valid_r <= 2'b00;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (done_s) begin
            rsp_valid_r <= gnt_r ? 2'b10 : 2'b01;
            rsp_err_r   <= timeout_s | Pslverr;
            rsp_rdata_r <= (Pready && !pwrite_r) ? Prdata : {DATA_WIDTH{1'b0}};
        end else begin
            rsp_valid_r <= 2'b00;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
        end
    end

    assign Psel      = psel_r;
    assign Penable   = penable_r;
    assign Pwrite    = pwrite_r;
    assign Paddr     = paddr_r;
    assign Pwdata    = pwdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: transaction-level model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with a random APB slave.
module tb_apb_master_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            Pclk = 1'b0;
    logic            Presetn = 1'b0;
    logic [1:0]      req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, Pwdata;
    logic            rsp_err, Psel, Penable, Pwrite;
    logic [AW-1:0]   Paddr;

    logic [1:0]      s_valid = 2'b00;
    logic [1:0]      s_write = 2'b00;
    logic [AW-1:0]   s_addr [2];
    logic [DW-1:0]   s_wdata [2];
    logic            s_pready = 1'b0;
    logic            s_pslverr = 1'b0;
    logic [DW-1:0]   s_prdata = 32'h0;

    int tests = 0;
    int fails = 0;

    // Model of the controller in terms of "cycles since acceptance"
    bit              m_busy;
    int              m_age;
    bit              m_gnt, m_ptr, m_wr;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [1:0]      m_rv;
    bit              m_re;
    logic [DW-1:0]   m_rd;
    logic [1:0]      acc;

    always #5 Pclk = ~Pclk;

    apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .Pclk(Pclk), .Presetn(Presetn),
        .req_valid(s_valid), .req_write(s_write),
        .req_addr({s_addr[1], s_addr[0]}), .req_wdata({s_wdata[1], s_wdata[0]}),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata(s_prdata), .Pready(s_pready), .Pslverr(s_pslverr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_age = 0; m_gnt = 1'b0; m_ptr = 1'b0; m_wr = 1'b0;
        m_addr = '0; m_wdata = '0; m_rv = 2'b00; m_re = 1'b0; m_rd = '0;
    endtask

    // Called at posedge+1 with this cycle's inputs set; compares, advances model, returns at next posedge+1
    task automatic step();
        logic       g;
        logic [1:0] er;
        bit         ed;
        #3;
        if (!Presetn) model_reset();
        g  = s_valid[m_ptr] ? m_ptr : ~m_ptr;
        ed = Presetn && m_busy && (m_age >= 2) && (s_pready || (TO > 0 && (m_age - 2) == TO - 1));
        er = (Presetn && (!m_busy || ed) && (|s_valid)) ? (g ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", req_ready, er);
        chk("Psel", Psel, m_busy);
        chk("Penable", Penable, m_busy && m_age >= 2);
        chk("Pwrite", Pwrite, m_wr);
        chk("Paddr", Paddr, m_addr);
        chk("Pwdata", Pwdata, m_wdata);
        chk("rsp_valid", rsp_valid, m_rv);
        chk("rsp_err", rsp_err, m_re);
        chk("rsp_rdata", rsp_rdata, m_rd);
        acc = er;
        if (Presetn) begin
            m_rv = 2'b00; m_re = 1'b0; m_rd = '0;
            if (ed) begin
                m_rv = m_gnt ? 2'b10 : 2'b01;
                if (s_pready) begin
                    m_re = s_pslverr;
                    m_rd = m_wr ? '0 : s_prdata;
                end else begin
                    m_re = 1'b1;
                end
            end
            if (er != 2'b00) begin
                m_busy = 1'b1; m_age = 1; m_gnt = g; m_ptr = ~g;
                m_wr = s_write[g]; m_addr = s_addr[g]; m_wdata = s_wdata[g];
            end else if (ed) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_age++;
            end
        end
        @(posedge Pclk);
        #1;
    endtask

    // Issue one command from requester i from IDLE; waits<0 keeps Pready low forever.
    // Returns the number of ACCESS cycles observed before the response.
    task automatic run_cmd(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int waits, input bit err_rdy, input bit err_wait,
                           input logic [DW-1:0] rdata, output int n);
        s_valid = (i == 1) ? 2'b10 : 2'b01;
        s_write[i] = wr; s_addr[i] = a; s_wdata[i] = d;
        s_pready = 1'b0;
        #1;
        chk("dir_accept", req_ready, (i == 1) ? 2'b10 : 2'b01);
        step();
        s_valid = 2'b00;
        chk("dir_setup_psel", Psel, 1'b1);
        chk("dir_setup_penable", Penable, 1'b0);
        chk("dir_setup_paddr", Paddr, a);
        step();
        n = 0;
        while (rsp_valid == 2'b00 && n < 40) begin
            if (Penable === 1'b1) n++;
            s_pready  = (waits >= 0) && (n - 1 == waits);
            s_pslverr = s_pready ? err_rdy : err_wait;
            s_prdata  = s_pready ? rdata : 32'hBAD0BAD0;
            step();
        end
        s_pready = 1'b0; s_pslverr = 1'b0;
    endtask

    initial begin
        int n;
        int grants [8];
        int ng, idle_gaps, hang;
        s_addr[0] = '0; s_addr[1] = '0; s_wdata[0] = '0; s_wdata[1] = '0;
        model_reset();
        @(posedge Pclk); #1;
        step(); step();
        chk("reset_psel", Psel, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        Presetn = 1'b1;
        step();

        // Zero-wait write from requester 0
        run_cmd(0, 1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h0, n);
        chk("t1_access_cycles", n, 1);
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_err", rsp_err, 1'b0);
        chk("t1_rsp_rdata", rsp_rdata, 32'h0);
        chk("t1_pwdata_held", Pwdata, 32'hDEADBEEF);
        step();

        // Read from requester 1 with three wait states
        run_cmd(1, 1'b0, 8'h24, 32'h0, 3, 1'b0, 1'b0, 32'h1234, n);
        chk("t2_access_cycles", n, 4);
        chk("t2_rsp_valid", rsp_valid, 2'b10);
        chk("t2_rsp_rdata", rsp_rdata, 32'h1234);
        step();

        // Slave error with ready flags the response; error while not ready is ignored
        run_cmd(0, 1'b1, 8'h30, 32'h55, 2, 1'b1, 1'b1, 32'h0, n);
        chk("t4_err_write", rsp_err, 1'b1);
        step();
        run_cmd(1, 1'b0, 8'h31, 32'h0, 1, 1'b0, 1'b1, 32'hCAFE, n);
        chk("t4_err_ignored", rsp_err, 1'b0);
        chk("t4_rdata", rsp_rdata, 32'hCAFE);
        step();

        // Hung slave: timeout completes after TO ACCESS cycles
        run_cmd(0, 1'b0, 8'h40, 32'h0, -1, 1'b0, 1'b0, 32'h0, n);
        chk("t5_access_cycles", n, TO);
        chk("t5_rsp_err", rsp_err, 1'b1);
        chk("t5_rsp_rdata", rsp_rdata, 32'h0);
        chk("t5_psel_drop", Psel, 1'b0);
        step();

        // Reset during ACCESS, then continuous contention from both requesters
        s_valid = 2'b10; s_write[1] = 1'b1; s_addr[1] = 8'h77; s_wdata[1] = 32'h77;
        step();
        s_valid = 2'b00;
        step(); step();
        s_valid = 2'b11;
        Presetn = 1'b0;
        #1;
        chk("t6_psel", Psel, 1'b0);
        chk("t6_penable", Penable, 1'b0);
        chk("t6_paddr", Paddr, 8'h0);
        chk("t6_req_ready", req_ready, 2'b00);
        chk("t6_rsp_valid", rsp_valid, 2'b00);
        step(); step();
        Presetn = 1'b1;
        s_pready = 1'b1;
        ng = 0; idle_gaps = 0;
        for (int c = 0; c < 60 && ng < 8; c++) begin
            #1;
            if (ng > 0 && Psel !== 1'b1) idle_gaps++;
            if (req_ready == 2'b01) begin grants[ng] = 0; ng++; end
            else if (req_ready == 2'b10) begin grants[ng] = 1; ng++; end
            step();
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    s_write[i] = 1'($urandom); s_addr[i] = 8'($urandom); s_wdata[i] = $urandom;
                end
            end
        end
        chk("t3_grant_count", ng, 8);
        for (int k = 0; k < 8; k++) chk("t3_grant_order", grants[k], k % 2);
        chk("t3_no_idle", idle_gaps, 0);
        s_valid = 2'b00;
        for (int c = 0; c < 4; c++) step();

        // Randomized traffic against a random slave
        hang = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (acc[i] || !s_valid[i]) begin
                    s_valid[i] = ($urandom_range(0, 99) < 40);
                    s_write[i] = 1'($urandom); s_addr[i] = 8'($urandom); s_wdata[i] = $urandom;
                end
            end
            if (hang > 0) begin
                s_pready = 1'b0; hang--;
            end else begin
                if ($urandom_range(0, 149) == 0) hang = 20;
                s_pready = ($urandom_range(0, 3) != 0);
            end
            s_pslverr = 1'($urandom);
            s_prdata  = $urandom;
            Presetn   = !(c >= 2000 && c < 2002);
            if (!Presetn) acc = 2'b00;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
